// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 3-stage pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN,
        ST_LOAD_STALL
    } state_e;

    localparam logic [1:0]  PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0]  PC_SEL_BRANCH = 2'd1;
    localparam logic [31:0] NOP_INSTR     = 32'h00000013;

endpackage

// File: rtl/load_use_detect.sv
// Flags an instruction in F that reads the destination of a load sitting in DE.
module load_use_detect (
    input  logic       load_de,
    input  logic [4:0] rd_de,
    input  logic [4:0] rs1_f,
    input  logic [4:0] rs2_f,
    input  logic       rs1_used_f,
    input  logic       rs2_used_f,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = rs1_used_f && (rs1_f == rd_de);
        rs2_hit = rs2_used_f && (rs2_f == rd_de);
        // x0 is hardwired zero, so a load into it can never be consumed.
        lu      = load_de && (rd_de != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the F -> DE -> MW pipeline.
// Define PIPE_HAZARD_CTRL_PERF_EN to add stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_taken_de,
    input  logic        load_de,
    input  logic [4:0]  rd_de,
    input  logic [4:0]  rs1_f,
    input  logic [4:0]  rs2_f,
    input  logic        rs1_used_f,
    input  logic        rs2_used_f,
    input  logic        imem_valid,
    input  logic        dmem_req_mw,
    input  logic        dmem_ready,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        fde_en,
    output logic        fde_flush,
    output logic        demw_en
);

    localparam logic [2:0] LastCnt = 3'(LOAD_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       lu;
    logic       freeze;
    logic       br_fire;

    load_use_detect u_load_use_detect (
        .load_de    (load_de),
        .rd_de      (rd_de),
        .rs1_f      (rs1_f),
        .rs2_f      (rs2_f),
        .rs1_used_f (rs1_used_f),
        .rs2_used_f (rs2_used_f),
        .lu         (lu)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_en     = 1'b1;
        pc_sel    = PC_SEL_PLUS4;
        fde_en    = 1'b1;
        fde_flush = 1'b0;
        demw_en   = 1'b1;
        br_fire   = 1'b0;
        freeze    = dmem_req_mw && !dmem_ready;

        if (rst) begin
            pc_en   = 1'b0;
            fde_en  = 1'b0;
            demw_en = 1'b0;
        end else if (freeze) begin
            // Hold everything; an in-flight load stall pauses rather than advancing.
            pc_en   = 1'b0;
            fde_en  = 1'b0;
            demw_en = 1'b0;
        end else if (br_taken_de) begin
            br_fire   = 1'b1;
            pc_sel    = PC_SEL_BRANCH;
            fde_flush = 1'b1;
            state_d   = ST_RUN;
            cnt_d     = 3'd0;
        end else if (state_q == ST_LOAD_STALL) begin
            pc_en     = 1'b0;
            fde_flush = 1'b1;
            if (cnt_q == LastCnt) begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (lu) begin
            pc_en     = 1'b0;
            fde_flush = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = ST_LOAD_STALL;
                cnt_d   = 3'd1;
            end
        end else if (!imem_valid) begin
            pc_en     = 1'b0;
            fde_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q + {31'd0, !pc_en};
        flush_cnt_d = flush_cnt_q + {31'd0, br_fire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cyc_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus and are
// compared against a bubbles-remaining reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       br_taken_de;
    logic       load_de;
    logic [4:0] rd_de;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic       rs1_used_f;
    logic       rs2_used_f;
    logic       imem_valid;
    logic       dmem_req_mw;
    logic       dmem_ready;

    logic       pc_en     [2];
    logic [1:0] pc_sel    [2];
    logic       fde_en    [2];
    logic       fde_flush [2];
    logic       demw_en   [2];
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc [2];
    logic [31:0] perf_flush_cnt [2];
`endif

    int checks = 0;
    int errors = 0;

    int lat       [2] = '{1, 3};
    int left      [2] = '{0, 0};
    int stall_cnt [2] = '{0, 0};
    int flush_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_LAT(1)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .br_taken_de    (br_taken_de),
        .load_de        (load_de),
        .rd_de          (rd_de),
        .rs1_f          (rs1_f),
        .rs2_f          (rs2_f),
        .rs1_used_f     (rs1_used_f),
        .rs2_used_f     (rs2_used_f),
        .imem_valid     (imem_valid),
        .dmem_req_mw    (dmem_req_mw),
        .dmem_ready     (dmem_ready),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .perf_stall_cyc (perf_stall_cyc[0]),
        .perf_flush_cnt (perf_flush_cnt[0]),
`endif
        .pc_en          (pc_en[0]),
        .pc_sel         (pc_sel[0]),
        .fde_en         (fde_en[0]),
        .fde_flush      (fde_flush[0]),
        .demw_en        (demw_en[0])
    );

    pipe_hazard_ctrl #(.LOAD_LAT(3)) dut3 (
        .clk            (clk),
        .rst            (rst),
        .br_taken_de    (br_taken_de),
        .load_de        (load_de),
        .rd_de          (rd_de),
        .rs1_f          (rs1_f),
        .rs2_f          (rs2_f),
        .rs1_used_f     (rs1_used_f),
        .rs2_used_f     (rs2_used_f),
        .imem_valid     (imem_valid),
        .dmem_req_mw    (dmem_req_mw),
        .dmem_ready     (dmem_ready),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .perf_stall_cyc (perf_stall_cyc[1]),
        .perf_flush_cnt (perf_flush_cnt[1]),
`endif
        .pc_en          (pc_en[1]),
        .pc_sel         (pc_sel[1]),
        .fde_en         (fde_en[1]),
        .fde_flush      (fde_flush[1]),
        .demw_en        (demw_en[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst         = 1'b0;
        br_taken_de = 1'b0;
        load_de     = 1'b0;
        rd_de       = 5'd0;
        rs1_f       = 5'd0;
        rs2_f       = 5'd0;
        rs1_used_f  = 1'b0;
        rs2_used_f  = 1'b0;
        imem_valid  = 1'b1;
        dmem_req_mw = 1'b0;
        dmem_ready  = 1'b0;
    endtask

    // Predict this cycle's outputs, compare, then advance the model across the next edge.
    task automatic tick(input string tag);
        logic       e_pc_en, e_fde_en, e_flush, e_demw_en, hazard, frz;
        logic [1:0] e_sel;
        logic [5:0] obs_vec, exp_vec;
        #1;
        hazard = load_de && (rd_de != 5'd0) &&
                 ((rs1_used_f && rs1_f == rd_de) || (rs2_used_f && rs2_f == rd_de));
        frz = dmem_req_mw && !dmem_ready;
        for (int d = 0; d < 2; d++) begin
            e_pc_en = 1'b1; e_sel = 2'd0; e_fde_en = 1'b1; e_flush = 1'b0; e_demw_en = 1'b1;
            if (rst) begin
                e_pc_en = 1'b0; e_fde_en = 1'b0; e_demw_en = 1'b0;
            end else if (frz) begin
                e_pc_en = 1'b0; e_fde_en = 1'b0; e_demw_en = 1'b0;
            end else if (br_taken_de) begin
                e_sel = 2'd1; e_flush = 1'b1;
            end else if (left[d] > 0) begin
                e_pc_en = 1'b0; e_flush = 1'b1;
            end else if (hazard) begin
                e_pc_en = 1'b0; e_flush = 1'b1;
            end else if (!imem_valid) begin
                e_pc_en = 1'b0; e_flush = 1'b1;
            end
            obs_vec = {pc_en[d], pc_sel[d], fde_en[d], fde_flush[d], demw_en[d]};
            exp_vec = {e_pc_en, e_sel, e_fde_en, e_flush, e_demw_en};
            check($sformatf("%s/L%0d/ctl", tag, lat[d]), 32'(obs_vec), 32'(exp_vec));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
            check($sformatf("%s/L%0d/stall", tag, lat[d]), perf_stall_cyc[d], stall_cnt[d]);
            check($sformatf("%s/L%0d/flush", tag, lat[d]), perf_flush_cnt[d], flush_cnt[d]);
`endif
            if (rst) begin
                left[d] = 0; stall_cnt[d] = 0; flush_cnt[d] = 0;
            end else begin
                if (!e_pc_en) stall_cnt[d]++;
                if (frz) begin
                end else if (br_taken_de) begin
                    left[d] = 0; flush_cnt[d]++;
                end else if (left[d] > 0) begin
                    left[d]--;
                end else if (hazard) begin
                    left[d] = lat[d] - 1;
                end
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        tick("reset0");
        tick("reset1");
        idle();
        tick("run");

        // Load x5 consumed by rs1 of the next instruction.
        load_de = 1'b1; rd_de = 5'd5; rs1_f = 5'd5; rs1_used_f = 1'b1;
        tick("lu_x5");
        idle();
        for (int i = 0; i < 4; i++) tick("lu_after");

        // Load into x0 never stalls.
        load_de = 1'b1; rd_de = 5'd0; rs1_f = 5'd0; rs1_used_f = 1'b1;
        rs2_f = 5'd0; rs2_used_f = 1'b1;
        tick("lu_x0");
        idle();

        // Branch wins over load-use.
        br_taken_de = 1'b1; load_de = 1'b1; rd_de = 5'd7; rs2_f = 5'd7; rs2_used_f = 1'b1;
        tick("br_lu");
        idle();
        tick("br_after");

        // Freeze for 4 cycles during the second bubble.
        load_de = 1'b1; rd_de = 5'd9; rs1_f = 5'd9; rs1_used_f = 1'b1;
        tick("frz_b1");
        idle();
        dmem_req_mw = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick("frz_hold");
        idle();
        for (int i = 0; i < 4; i++) tick("frz_resume");

        // Fetch not ready.
        imem_valid = 1'b0;
        tick("imem0");
        tick("imem1");
        idle();
        tick("imem_after");

        // Reset in the middle of a load stall.
        load_de = 1'b1; rd_de = 5'd3; rs2_f = 5'd3; rs2_used_f = 1'b1;
        tick("rst_b1");
        idle();
        tick("rst_b2");
        rst = 1'b1;
        tick("rst_mid");
        idle();
        tick("rst_after");
        tick("rst_after2");

        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            br_taken_de = ($urandom_range(0, 7) == 0);
            load_de     = ($urandom_range(0, 2) == 0);
            rd_de       = 5'($urandom_range(0, 3));
            rs1_f       = 5'($urandom_range(0, 3));
            rs2_f       = 5'($urandom_range(0, 3));
            rs1_used_f  = 1'($urandom_range(0, 1));
            rs2_used_f  = 1'($urandom_range(0, 1));
            imem_valid  = ($urandom_range(0, 5) != 0);
            dmem_req_mw = ($urandom_range(0, 2) == 0);
            dmem_ready  = ($urandom_range(0, 2) != 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
